// File: rtl/volume_scaler.sv
// rtl/volume_scaler.sv - stereo PCM attenuator with per-sample dB ramp and 2-stage handshake pipeline
module volume_scaler #(
    parameter int MAX_DB = 43
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_muted,
    input  logic [5:0]  lch_db,
    input  logic [5:0]  rch_db,
    input  logic        db_val_valid,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_left,
    input  logic [15:0] in_right,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_left,
    output logic [15:0] out_right
);
    localparam logic [6:0] MUTE_IDX = 7'd64;

    logic [5:0]         code_l_q, code_r_q, code_l_d, code_r_d;
    logic [6:0]         idx_l_q, idx_r_q, idx_l_d, idx_r_d;
    logic [6:0]         tgt_l, tgt_r;
    logic               s1_valid_q;
    logic signed [15:0] s1_left_q, s1_right_q;
    logic [15:0]        s1_gain_l_q, s1_gain_r_q;
    logic               out_valid_q;
    logic signed [15:0] out_left_q, out_right_q;
    logic               advance, accept;

    function automatic logic [5:0] clamp_code(input logic [5:0] code);
        return (code > 6'(MAX_DB)) ? 6'(MAX_DB) : code;
    endfunction

    function automatic logic [6:0] step_toward(input logic [6:0] cur, input logic [6:0] tgt);
        if (cur < tgt)
            return cur + 7'd1;
        else if (cur > tgt)
            return cur - 7'd1;
        return cur;
    endfunction

    // round(32768 * 10^(-n/20)), entry 0 saturated; 64 and above is silence
    function automatic logic [15:0] gain_lut(input logic [6:0] idx);
        logic [15:0] g;
        case (idx)
            7'd0:  g = 16'd32767; 7'd1:  g = 16'd29205; 7'd2:  g = 16'd26029; 7'd3:  g = 16'd23198;
            7'd4:  g = 16'd20675; 7'd5:  g = 16'd18427; 7'd6:  g = 16'd16423; 7'd7:  g = 16'd14637;
            7'd8:  g = 16'd13045; 7'd9:  g = 16'd11627; 7'd10: g = 16'd10362; 7'd11: g = 16'd9235;
            7'd12: g = 16'd8231;  7'd13: g = 16'd7336;  7'd14: g = 16'd6538;  7'd15: g = 16'd5827;
            7'd16: g = 16'd5193;  7'd17: g = 16'd4629;  7'd18: g = 16'd4125;  7'd19: g = 16'd3677;
            7'd20: g = 16'd3277;  7'd21: g = 16'd2920;  7'd22: g = 16'd2603;  7'd23: g = 16'd2320;
            7'd24: g = 16'd2068;  7'd25: g = 16'd1843;  7'd26: g = 16'd1642;  7'd27: g = 16'd1464;
            7'd28: g = 16'd1305;  7'd29: g = 16'd1163;  7'd30: g = 16'd1036;  7'd31: g = 16'd924;
            7'd32: g = 16'd823;   7'd33: g = 16'd734;   7'd34: g = 16'd654;   7'd35: g = 16'd583;
            7'd36: g = 16'd519;   7'd37: g = 16'd463;   7'd38: g = 16'd413;   7'd39: g = 16'd368;
            7'd40: g = 16'd328;   7'd41: g = 16'd292;   7'd42: g = 16'd260;   7'd43: g = 16'd232;
            7'd44: g = 16'd207;   7'd45: g = 16'd184;   7'd46: g = 16'd164;   7'd47: g = 16'd146;
            7'd48: g = 16'd130;   7'd49: g = 16'd116;   7'd50: g = 16'd104;   7'd51: g = 16'd92;
            7'd52: g = 16'd82;    7'd53: g = 16'd73;    7'd54: g = 16'd65;    7'd55: g = 16'd58;
            7'd56: g = 16'd52;    7'd57: g = 16'd46;    7'd58: g = 16'd41;    7'd59: g = 16'd37;
            7'd60: g = 16'd33;    7'd61: g = 16'd29;    7'd62: g = 16'd26;    7'd63: g = 16'd23;
            default: g = 16'd0;
        endcase
        return g;
    endfunction

    // Q15 multiply with round-half-up, then clip to the 16-bit range
    function automatic logic signed [15:0] scale(input logic signed [15:0] s, input logic [15:0] g);
        logic signed [31:0] s_x;
        logic signed [31:0] g_x;
        logic signed [31:0] acc;
        s_x = 32'(s);
        g_x = $signed({16'd0, g});
        acc = (s_x * g_x + 32'sd16384) >>> 15;
        if (acc > 32'sd32767)
            return 16'sh7fff;
        else if (acc < -32'sd32768)
            return 16'sh8000;
        return acc[15:0];
    endfunction

    assign advance   = out_ready | ~out_valid_q;
    assign accept    = in_valid & advance;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_left  = out_left_q;
    assign out_right = out_right_q;

    // Targets use the already-latched codes so a same-cycle strobe only affects later steps
    always_comb begin
        code_l_d = code_l_q;
        code_r_d = code_r_q;
        if (db_val_valid) begin
            code_l_d = clamp_code(lch_db);
            code_r_d = clamp_code(rch_db);
        end
        tgt_l   = is_muted ? MUTE_IDX : {1'b0, code_l_q};
        tgt_r   = is_muted ? MUTE_IDX : {1'b0, code_r_q};
        idx_l_d = idx_l_q;
        idx_r_d = idx_r_q;
        if (accept) begin
            idx_l_d = step_toward(idx_l_q, tgt_l);
            idx_r_d = step_toward(idx_r_q, tgt_r);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_l_q    <= 6'd0;
            code_r_q    <= 6'd0;
            idx_l_q     <= MUTE_IDX;
            idx_r_q     <= MUTE_IDX;
            s1_valid_q  <= 1'b0;
            s1_left_q   <= 16'sd0;
            s1_right_q  <= 16'sd0;
            s1_gain_l_q <= 16'd0;
            s1_gain_r_q <= 16'd0;
            out_valid_q <= 1'b0;
            out_left_q  <= 16'sd0;
            out_right_q <= 16'sd0;
        end else begin
            code_l_q <= code_l_d;
            code_r_q <= code_r_d;
            idx_l_q  <= idx_l_d;
            idx_r_q  <= idx_r_d;
            if (advance) begin
                s1_valid_q  <= in_valid;
                out_valid_q <= s1_valid_q;
                if (in_valid) begin
                    s1_left_q   <= in_left;
                    s1_right_q  <= in_right;
                    s1_gain_l_q <= gain_lut(idx_l_q);
                    s1_gain_r_q <= gain_lut(idx_r_q);
                end
                if (s1_valid_q) begin
                    out_left_q  <= scale(s1_left_q, s1_gain_l_q);
                    out_right_q <= scale(s1_right_q, s1_gain_r_q);
                end
            end
        end
    end
endmodule
